// File: rtl/if_prefetch_queue_if.sv
// IF -> prefetch queue -> ID handshake bundle.
// slave: the queue side; master: the IF/ID pipeline side that drives pushes, stall and flush.
interface if_prefetch_queue_if #(
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] in_pc;
    logic [DATA_W-1:0] in_insn;
    logic              in_en;
    logic              in_ready;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_insn;
    logic              out_en;
    logic [PTR_W:0]    count;

    modport slave (
        input  in_pc, in_insn, in_en, stall, flush,
        output in_ready, out_pc, out_insn, out_en, count
    );

    modport master (
        output in_pc, in_insn, in_en, stall, flush,
        input  in_ready, out_pc, out_insn, out_en, count
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// {pc, insn} prefetch FIFO between IF and ID; flush empties it.
// Optional IF_PREFETCH_BYPASS_EN: same-cycle bypass from IF to ID while the queue is empty.
module if_prefetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    if_prefetch_queue_if.slave pq
);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_insn [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [PTR_W:0]    cnt;
    logic              empty;
    logic              wr;
    logic              rd;

    assign empty       = (cnt == '0);
    assign pq.in_ready = (cnt != CNT_FULL);
    assign pq.count    = cnt;
    assign rd          = ~empty & ~pq.stall;

`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass;

    // An entry consumed straight off the IF bus never touches storage.
    assign bypass      = empty & pq.in_en & ~pq.flush;
    assign wr          = pq.in_en & pq.in_ready & ~(bypass & ~pq.stall);
    assign pq.out_en   = ~empty | bypass;
    assign pq.out_pc   = ~empty ? mem_pc[rp]   : (bypass ? pq.in_pc   : '0);
    assign pq.out_insn = ~empty ? mem_insn[rp] : (bypass ? pq.in_insn : '0);
`else
    assign wr          = pq.in_en & pq.in_ready;
    assign pq.out_en   = ~empty;
    assign pq.out_pc   = empty ? '0 : mem_pc[rp];
    assign pq.out_insn = empty ? '0 : mem_insn[rp];
`endif

    always_ff @(posedge clk) begin
        if (reset || pq.flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + PTR_ONE;
            if (rd) rp <= rp + PTR_ONE;
            if (wr && !rd)
                cnt <= cnt + CNT_ONE;
            else if (rd && !wr)
                cnt <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !reset && !pq.flush) begin
            mem_pc[wp]   <= pq.in_pc;
            mem_insn[wp] <= pq.in_insn;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: stimulus process plus a negedge scoreboard monitor.
module tb_if_prefetch_queue;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
`ifdef IF_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] insn;
    } ent_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    bit   seen_55;
    ent_t exp_q[$];

    if_prefetch_queue_if #(.PTR_W(PTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    if_prefetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .pq    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: reference queue updated every cycle, outputs compared against its head.
    always @(negedge clk) begin
        int   sz;
        bit   byp;
        bit   vis;
        bit   pop;
        ent_t head;
        if (bus.out_en && bus.out_pc == 30'h55) seen_55 = 1'b1;
        if (reset) begin
            exp_q.delete();
        end else begin
            sz   = exp_q.size();
            byp  = BYP && sz == 0 && bus.in_en && !bus.flush;
            vis  = (sz != 0) || byp;
            head = '0;
            if (sz != 0) head = exp_q[0];
            else if (byp) head = '{bus.in_pc, bus.in_insn};
            check("mon_out_en", 64'(bus.out_en), 64'(vis));
            check("mon_count", 64'(bus.count), 64'(sz));
            check("mon_in_ready", 64'(bus.in_ready), 64'(sz != DEPTH));
            check("mon_out_pc", 64'(bus.out_pc), 64'(head.pc));
            check("mon_out_insn", 64'(bus.out_insn), 64'(head.insn));
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                pop = vis && !bus.stall;
                if (pop && sz != 0) void'(exp_q.pop_front());
                if (bus.in_en && sz != DEPTH && !(byp && pop))
                    exp_q.push_back('{bus.in_pc, bus.in_insn});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] insn);
        bus.in_en   = en;
        bus.in_pc   = pc;
        bus.in_insn = insn;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        seen_55 = 1'b0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, '0, '0);
        step();
        step();
        reset = 1'b0;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_en", 64'(bus.out_en), 64'd0);
        check("rst_out_pc", 64'(bus.out_pc), 64'd0);
        check("rst_out_insn", 64'(bus.out_insn), 64'd0);

        // Fill to full under stall, then try a fifth push.
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 30'h10 + 30'(i), 32'hA000_0001 + 32'(i));
            step();
        end
        check("full_count", 64'(bus.count), 64'd4);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_out_pc", 64'(bus.out_pc), 64'h10);
        drive(1'b1, 30'h14, 32'hA000_0005);
        step();
        check("refused_count", 64'(bus.count), 64'd4);

        // Drain in order.
        drive(1'b0, '0, '0);
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_out_pc", 64'(bus.out_pc), 64'h10 + 64'(i));
            check("drain_out_insn", 64'(bus.out_insn), 64'hA000_0001 + 64'(i));
            step();
        end
        check("drained_out_en", 64'(bus.out_en), 64'd0);
        check("drained_out_insn", 64'(bus.out_insn), 64'd0);
        check("drained_count", 64'(bus.count), 64'd0);

        // Streaming push+pop across pointer wrap.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 30'h100 + 30'(i), 32'hB000_0000 + 32'(i));
            step();
        end
        check("stream_count", 64'(bus.count), BYP ? 64'd0 : 64'd1);
        drive(1'b0, '0, '0);
        step();
        check("stream_drained", 64'(bus.count), 64'd0);

        // Flush beats a same-cycle push.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 30'h50 + 30'(i), 32'hD000_0000 + 32'(i));
            step();
        end
        check("preflush_count", 64'(bus.count), 64'd3);
        drive(1'b1, 30'h55, 32'hD000_0055);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_out_en", 64'(bus.out_en), 64'd0);
        bus.stall = 1'b0;
        step();
        step();

        // Reset mid-operation with a push in flight.
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 30'h60 + 30'(i), 32'hE000_0000 + 32'(i));
            step();
        end
        check("prerst_count", 64'(bus.count), 64'd2);
        drive(1'b1, 30'h62, 32'hE000_0002);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, '0, '0);
        check("midrst_count", 64'(bus.count), 64'd0);
        check("midrst_out_en", 64'(bus.out_en), 64'd0);
        check("midrst_out_pc", 64'(bus.out_pc), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);

        // Push into empty queue: bypass shows it now, otherwise next cycle.
        bus.stall = 1'b0;
        drive(1'b1, 30'h20, 32'hC000_0020);
        check("empty_push_same_en", 64'(bus.out_en), BYP ? 64'd1 : 64'd0);
        check("empty_push_same_pc", 64'(bus.out_pc), BYP ? 64'h20 : 64'd0);
        step();
        drive(1'b0, '0, '0);
        check("empty_push_next_count", 64'(bus.count), BYP ? 64'd0 : 64'd1);
        check("empty_push_next_en", 64'(bus.out_en), BYP ? 64'd0 : 64'd1);
        check("empty_push_next_pc", 64'(bus.out_pc), BYP ? 64'd0 : 64'h20);
        step();
        step();
        check("flushed_55_never_seen", 64'(seen_55), 64'd0);
        check("final_count", 64'(bus.count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
